// File: rtl/ddr_port_arbiter.sv
// ddr_port_arbiter: shares one cache-to-DDR read/write port between the
// instruction cache (port 0) and the data cache (port 1). Requests are
// serialised one at a time, round-robin between ports, and within a port a
// pending write goes ahead of a pending read. Completion pulses and read data
// are routed back to the port that owned the transaction.
module ddr_port_arbiter #(
  parameter int unsigned ADDR_W = 27,
  parameter int unsigned DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,

  // Port 0: instruction cache
  input  logic [ADDR_W-1:0] cache0_rd_addr,
  input  logic              cache0_rd_en,
  output logic              cache0_rd_fin,
  output logic [DATA_W-1:0] cache0_rd_data,
  input  logic [ADDR_W-1:0] cache0_wr_addr,
  input  logic [DATA_W-1:0] cache0_wr_data,
  input  logic              cache0_wr_en,
  output logic              cache0_wr_fin,

  // Port 1: data cache
  input  logic [ADDR_W-1:0] cache1_rd_addr,
  input  logic              cache1_rd_en,
  output logic              cache1_rd_fin,
  output logic [DATA_W-1:0] cache1_rd_data,
  input  logic [ADDR_W-1:0] cache1_wr_addr,
  input  logic [DATA_W-1:0] cache1_wr_data,
  input  logic              cache1_wr_en,
  output logic              cache1_wr_fin,

  // Shared DDR side
  output logic [ADDR_W-1:0] arb2DDR_rd_addr,
  output logic              arb2DDR_rd_en,
  input  logic              DDR2arb_rd_fin,
  input  logic [DATA_W-1:0] DDR2arb_rd_data,
  output logic [ADDR_W-1:0] arb2DDR_wr_addr,
  output logic [DATA_W-1:0] arb2DDR_wr_data,
  output logic              arb2DDR_wr_en,
  input  logic              DDR2arb_wr_fin,

  // Status
  output logic              busy,
  output logic              grant_port
);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StRecover
  } state_e;

  state_e            r_state;
  state_e            w_state_next;

  // Latched transaction: owner, direction, address and write line
  logic              r_port;
  logic              r_last_port;
  logic              r_op_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wr_data;

  // Per-port completion pulses and held read lines
  logic              r_c0_rd_fin;
  logic              r_c0_wr_fin;
  logic              r_c1_rd_fin;
  logic              r_c1_wr_fin;
  logic [DATA_W-1:0] r_c0_rd_data;
  logic [DATA_W-1:0] r_c1_rd_data;

  // Request decode
  logic              w_req0;
  logic              w_req1;
  logic              w_any_req;
  logic              w_pick;
  logic              w_pick_wr;
  logic [ADDR_W-1:0] w_pick_addr;
  logic [DATA_W-1:0] w_pick_data;
  logic              w_grant;
  logic              w_ddr_done;
  logic              w_complete;

  assign w_req0    = cache0_rd_en | cache0_wr_en;
  assign w_req1    = cache1_rd_en | cache1_wr_en;
  assign w_any_req = w_req0 | w_req1;

  // Choose the port to grant and what it wants; only meaningful in IDLE
  always_comb begin
    w_pick      = 1'b0;
    w_pick_wr   = 1'b0;
    w_pick_addr = '0;
    w_pick_data = '0;
    // On a tie the port that did not win last time goes next
    if (w_req0 && w_req1) begin
      w_pick = ~r_last_port;
    end else begin
      w_pick = w_req1;
    end
    if (w_pick) begin
      w_pick_wr   = cache1_wr_en;
      w_pick_addr = cache1_wr_en ? cache1_wr_addr : cache1_rd_addr;
      w_pick_data = cache1_wr_data;
    end else begin
      w_pick_wr   = cache0_wr_en;
      w_pick_addr = cache0_wr_en ? cache0_wr_addr : cache0_rd_addr;
      w_pick_data = cache0_wr_data;
    end
  end

  // Only the completion of the op actually issued counts
  assign w_ddr_done = r_op_wr ? DDR2arb_wr_fin : DDR2arb_rd_fin;
  assign w_grant    = (r_state == StIdle) && w_any_req;
  assign w_complete = (r_state == StIssue) && w_ddr_done;

  // Next-state decode for the IDLE / ISSUE / RECOVER sequence
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_any_req) begin
          w_state_next = StIssue;
        end
      end
      StIssue: begin
        if (w_ddr_done) begin
          w_state_next = StRecover;
        end
      end
      StRecover: begin
        // Wait out any DDR fin that lasts longer than one cycle so it is not
        // mistaken for the completion of the next transaction
        if (!DDR2arb_rd_fin && !DDR2arb_wr_fin) begin
          w_state_next = StIdle;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // State register and transaction latch
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_port      <= 1'b0;
      r_last_port <= 1'b1;
      r_op_wr     <= 1'b0;
      r_addr      <= '0;
      r_wr_data   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_grant) begin
        r_port      <= w_pick;
        r_last_port <= w_pick;
        r_op_wr     <= w_pick_wr;
        r_addr      <= w_pick_addr;
        r_wr_data   <= w_pick_data;
      end
    end
  end

  // Completion pulses to the owning port and read-line capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_c0_rd_fin  <= 1'b0;
      r_c0_wr_fin  <= 1'b0;
      r_c1_rd_fin  <= 1'b0;
      r_c1_wr_fin  <= 1'b0;
      r_c0_rd_data <= '0;
      r_c1_rd_data <= '0;
    end else begin
      r_c0_rd_fin <= w_complete && !r_port && !r_op_wr;
      r_c0_wr_fin <= w_complete && !r_port &&  r_op_wr;
      r_c1_rd_fin <= w_complete &&  r_port && !r_op_wr;
      r_c1_wr_fin <= w_complete &&  r_port &&  r_op_wr;
      if (w_complete && !r_op_wr) begin
        if (r_port) begin
          r_c1_rd_data <= DDR2arb_rd_data;
        end else begin
          r_c0_rd_data <= DDR2arb_rd_data;
        end
      end
    end
  end

  // DDR enables follow the state directly so they drop the cycle after fin
  assign arb2DDR_rd_en   = (r_state == StIssue) && !r_op_wr;
  assign arb2DDR_wr_en   = (r_state == StIssue) &&  r_op_wr;
  assign arb2DDR_rd_addr = r_addr;
  assign arb2DDR_wr_addr = r_addr;
  assign arb2DDR_wr_data = r_wr_data;

  assign cache0_rd_fin  = r_c0_rd_fin;
  assign cache0_wr_fin  = r_c0_wr_fin;
  assign cache1_rd_fin  = r_c1_rd_fin;
  assign cache1_wr_fin  = r_c1_wr_fin;
  assign cache0_rd_data = r_c0_rd_data;
  assign cache1_rd_data = r_c1_rd_data;

  assign busy       = (r_state != StIdle);
  assign grant_port = r_port;

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Directed bench for ddr_port_arbiter with a small DDR model whose fin pulse
// starts one cycle after an enable and lasts a programmable number of cycles.
module tb_ddr_port_arbiter;

  localparam int unsigned ADDR_W = 27;
  localparam int unsigned DATA_W = 128;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] cache0_rd_addr, cache0_wr_addr, cache1_rd_addr, cache1_wr_addr;
  logic [DATA_W-1:0] cache0_wr_data, cache1_wr_data;
  logic              cache0_rd_en, cache0_wr_en, cache1_rd_en, cache1_wr_en;
  logic              cache0_rd_fin, cache0_wr_fin, cache1_rd_fin, cache1_wr_fin;
  logic [DATA_W-1:0] cache0_rd_data, cache1_rd_data;
  logic [ADDR_W-1:0] arb2DDR_rd_addr, arb2DDR_wr_addr;
  logic [DATA_W-1:0] arb2DDR_wr_data;
  logic              arb2DDR_rd_en, arb2DDR_wr_en;
  logic              DDR2arb_rd_fin, DDR2arb_wr_fin;
  logic [DATA_W-1:0] DDR2arb_rd_data;
  logic              busy, grant_port;

  int checks   = 0;
  int failures = 0;

  ddr_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dut (
    .clk             (clk),
    .rst             (rst),
    .cache0_rd_addr  (cache0_rd_addr),
    .cache0_rd_en    (cache0_rd_en),
    .cache0_rd_fin   (cache0_rd_fin),
    .cache0_rd_data  (cache0_rd_data),
    .cache0_wr_addr  (cache0_wr_addr),
    .cache0_wr_data  (cache0_wr_data),
    .cache0_wr_en    (cache0_wr_en),
    .cache0_wr_fin   (cache0_wr_fin),
    .cache1_rd_addr  (cache1_rd_addr),
    .cache1_rd_en    (cache1_rd_en),
    .cache1_rd_fin   (cache1_rd_fin),
    .cache1_rd_data  (cache1_rd_data),
    .cache1_wr_addr  (cache1_wr_addr),
    .cache1_wr_data  (cache1_wr_data),
    .cache1_wr_en    (cache1_wr_en),
    .cache1_wr_fin   (cache1_wr_fin),
    .arb2DDR_rd_addr (arb2DDR_rd_addr),
    .arb2DDR_rd_en   (arb2DDR_rd_en),
    .DDR2arb_rd_fin  (DDR2arb_rd_fin),
    .DDR2arb_rd_data (DDR2arb_rd_data),
    .arb2DDR_wr_addr (arb2DDR_wr_addr),
    .arb2DDR_wr_data (arb2DDR_wr_data),
    .arb2DDR_wr_en   (arb2DDR_wr_en),
    .DDR2arb_wr_fin  (DDR2arb_wr_fin),
    .busy            (busy),
    .grant_port      (grant_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DDR model: 256-line memory indexed by the low address byte
  logic [DATA_W-1:0] mem [0:255];
  int                fin_len = 2;
  int                m_left;
  logic              m_is_wr;
  logic [DATA_W-1:0] m_data;
  logic              pre_we;
  logic [7:0]        pre_addr;
  logic [DATA_W-1:0] pre_data;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    if (m_left != 0) begin
      m_left <= m_left - 1;
    end else if (arb2DDR_rd_en || arb2DDR_wr_en) begin
      m_left  <= fin_len;
      m_is_wr <= arb2DDR_wr_en;
      if (arb2DDR_wr_en) mem[arb2DDR_wr_addr[7:0]] <= arb2DDR_wr_data;
      else m_data <= mem[arb2DDR_rd_addr[7:0]];
    end
  end

  assign DDR2arb_rd_fin  = (m_left != 0) && !m_is_wr;
  assign DDR2arb_wr_fin  = (m_left != 0) &&  m_is_wr;
  assign DDR2arb_rd_data = DDR2arb_rd_fin ? m_data : '0;

  // Protocol monitors: enable overlap and completion pulse counts
  int both_hi = 0;
  int n_c0rd = 0, n_c0wr = 0, n_c1rd = 0, n_c1wr = 0;
  always @(posedge clk) begin
    if (arb2DDR_rd_en && arb2DDR_wr_en) both_hi <= both_hi + 1;
    if (cache0_rd_fin) n_c0rd <= n_c0rd + 1;
    if (cache0_wr_fin) n_c0wr <= n_c0wr + 1;
    if (cache1_rd_fin) n_c1rd <= n_c1rd + 1;
    if (cache1_wr_fin) n_c1wr <= n_c1wr + 1;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic fin_sel(input int which);
    case (which)
      0:       return cache0_rd_fin;
      1:       return cache0_wr_fin;
      2:       return cache1_rd_fin;
      3:       return cache1_wr_fin;
      default: return cache0_rd_fin | cache1_rd_fin;
    endcase
  endfunction

  // Wait up to 12 cycles for the selected fin; cyc = cycles waited
  task automatic wait_fin(input string tag, input int which, output int cyc);
    cyc = 0;
    while (!fin_sel(which) && cyc < 12) begin
      tick();
      cyc++;
    end
    check({tag, "_seen"}, fin_sel(which), 1'b1);
  endtask

  task automatic preload(input logic [7:0] a, input logic [DATA_W-1:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    tick();
    pre_we   = 1'b0;
  endtask

  int cyc;
  int snap0, snap1;
  int exp_port;

  initial begin
    rst = 1'b1;
    m_left = 0; m_is_wr = 1'b0; m_data = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    cache0_rd_addr = '0; cache0_wr_addr = '0; cache1_rd_addr = '0; cache1_wr_addr = '0;
    cache0_wr_data = '0; cache1_wr_data = '0;
    cache0_rd_en = 1'b0; cache0_wr_en = 1'b0; cache1_rd_en = 1'b0; cache1_wr_en = 1'b0;

    preload(8'h10, {16{8'hA5}});
    preload(8'h30, 128'h3333);
    preload(8'h40, 128'h4444);
    preload(8'h50, 128'h0);
    tick();

    // Reset state
    check("rst_busy", busy, 1'b0);
    check("rst_grant", grant_port, 1'b0);
    check("rst_ddr_en", {arb2DDR_rd_en, arb2DDR_wr_en}, 2'b00);
    check("rst_fins", {cache0_rd_fin, cache0_wr_fin, cache1_rd_fin, cache1_wr_fin}, 4'b0);
    check("rst_addr", arb2DDR_rd_addr, '0);

    // Single read on port 0, cycle-exact against the 2-cycle-fin model
    rst = 1'b0;
    cache0_rd_addr = 27'h10;
    cache0_rd_en   = 1'b1;
    tick();  // cycle 1
    check("t1_c1_rd_en", arb2DDR_rd_en, 1'b1);
    check("t1_c1_wr_en", arb2DDR_wr_en, 1'b0);
    check("t1_c1_addr", arb2DDR_rd_addr, 27'h10);
    check("t1_c1_busy", busy, 1'b1);
    tick();  // cycle 2
    check("t1_c2_fin", cache0_rd_fin, 1'b0);
    tick();  // cycle 3
    check("t1_c3_fin", cache0_rd_fin, 1'b1);
    check("t1_c3_data", cache0_rd_data, {16{8'hA5}});
    check("t1_c3_ddr_en", arb2DDR_rd_en, 1'b0);
    check("t1_c3_p1_out", {cache1_rd_fin, cache1_wr_fin}, 2'b00);
    check("t1_c3_p1_data", cache1_rd_data, '0);
    tick();  // cycle 4
    cache0_rd_en = 1'b0;
    check("t1_c4_pulse", cache0_rd_fin, 1'b0);
    check("t1_c4_busy", busy, 1'b1);
    tick();  // cycle 5
    check("t1_c5_idle", busy, 1'b0);

    // Port 1 write then read-back
    cache1_wr_addr = 27'h20;
    cache1_wr_data = 128'h1234;
    cache1_wr_en   = 1'b1;
    wait_fin("t2_wr", 3, cyc);
    check("t2_wr_latency", cyc, 3);
    check("t2_wr_grant", grant_port, 1'b1);
    tick();
    cache1_wr_en   = 1'b0;
    cache1_rd_addr = 27'h20;
    cache1_rd_en   = 1'b1;
    wait_fin("t2_rd", 2, cyc);
    check("t2_rd_data", cache1_rd_data, 128'h1234);
    check("t2_wr_count", n_c1wr, 1);
    tick();
    cache1_rd_en = 1'b0;
    repeat (3) tick();

    // Simultaneous reads straight out of reset alternate 0,1,0,1
    rst = 1'b1;
    tick();
    check("t3_rst_data", cache1_rd_data, '0);
    rst = 1'b0;
    cache0_rd_addr = 27'h30;
    cache1_rd_addr = 27'h40;
    cache0_rd_en   = 1'b1;
    cache1_rd_en   = 1'b1;
    for (int r = 0; r < 4; r++) begin
      exp_port = r % 2;
      wait_fin("t3_round", 4, cyc);
      check("t3_grant", grant_port, exp_port[0]);
      check("t3_fin0", cache0_rd_fin, exp_port == 0);
      check("t3_fin1", cache1_rd_fin, exp_port == 1);
      if (exp_port == 0) check("t3_data0", cache0_rd_data, 128'h3333);
      else check("t3_data1", cache1_rd_data, 128'h4444);
      tick();
      if (exp_port == 0) cache0_rd_en = 1'b0;
      else cache1_rd_en = 1'b0;
      tick();
      if (r < 2) begin
        if (exp_port == 0) cache0_rd_en = 1'b1;
        else cache1_rd_en = 1'b1;
      end
    end
    cache0_rd_en = 1'b0;
    cache1_rd_en = 1'b0;
    repeat (3) tick();

    // Port 0 read and write together: write first, read sees the new line
    snap0 = n_c0rd;
    cache0_wr_addr = 27'h50;
    cache0_rd_addr = 27'h50;
    cache0_wr_data = 128'hBEEF;
    cache0_wr_en   = 1'b1;
    cache0_rd_en   = 1'b1;
    wait_fin("t4_wr", 1, cyc);
    check("t4_wr_latency", cyc, 3);
    check("t4_no_rd_yet", n_c0rd, snap0);
    check("t4_rd_fin_low", cache0_rd_fin, 1'b0);
    tick();
    cache0_wr_en = 1'b0;
    wait_fin("t4_rd", 0, cyc);
    check("t4_rd_data", cache0_rd_data, 128'hBEEF);
    tick();
    cache0_rd_en = 1'b0;
    repeat (3) tick();
    check("t4_both_hi", both_hi, 0);

    // Long DDR fin: RECOVER holds until fin falls, single requester pulse
    fin_len = 3;
    snap0 = n_c0rd;
    cache0_rd_addr = 27'h10;
    cache0_rd_en   = 1'b1;
    wait_fin("t5_rd", 0, cyc);
    check("t5_latency", cyc, 3);
    tick();  // cycle 4
    cache0_rd_en = 1'b0;
    check("t5_c4_busy", busy, 1'b1);
    check("t5_c4_ddr_en", arb2DDR_rd_en, 1'b0);
    check("t5_c4_pulse", cache0_rd_fin, 1'b0);
    tick();  // cycle 5
    check("t5_c5_busy", busy, 1'b1);
    check("t5_c5_ddr_en", arb2DDR_rd_en, 1'b0);
    tick();  // cycle 6
    check("t5_c6_idle", busy, 1'b0);
    check("t5_count", n_c0rd, snap0 + 1);
    fin_len = 2;
    repeat (3) tick();

    // Reset during ISSUE of a port 1 write
    snap1 = n_c1wr;
    cache1_wr_addr = 27'h60;
    cache1_wr_data = 128'h77;
    cache1_wr_en   = 1'b1;
    tick();  // cycle 1
    check("t6_c1_wr_en", arb2DDR_wr_en, 1'b1);
    check("t6_c1_grant", grant_port, 1'b1);
    rst = 1'b1;
    tick();  // cycle 2
    check("t6_ddr_en", {arb2DDR_rd_en, arb2DDR_wr_en}, 2'b00);
    check("t6_busy", busy, 1'b0);
    check("t6_grant", grant_port, 1'b0);
    check("t6_wr_addr", arb2DDR_wr_addr, '0);
    check("t6_wr_data", arb2DDR_wr_data, '0);
    check("t6_c0_data", cache0_rd_data, '0);
    check("t6_c1_wr_fin", cache1_wr_fin, 1'b0);
    rst = 1'b0;
    cache1_wr_en = 1'b0;
    repeat (3) tick();
    cache0_rd_addr = 27'h40;
    cache0_rd_en   = 1'b1;
    wait_fin("t6_rd", 0, cyc);
    check("t6_rd_data", cache0_rd_data, 128'h4444);
    tick();
    cache0_rd_en = 1'b0;
    repeat (3) tick();
    check("t6_no_wr_fin", n_c1wr, snap1);
    check("final_both_hi", both_hi, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ddr_port_arbiter.md
# ddr_port_arbiter

Two-requester arbiter sharing the single cache-to-DDR read/write port between the instruction cache (port 0) and the data cache (port 1). Each cache side presents the same level-held request / single-cycle `fin` protocol it would use against DDR directly; the arbiter serialises the requests onto the DDR side one at a time and routes completion and read data back to the owner. Round-robin between ports; within a port, a pending write is serviced before a pending read.

## Interface
- `ADDR_W`, 27, address width on all ports
- `DATA_W`, 128, line width on all ports

- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `cacheN_rd_addr`  in  ADDR_W  read address, N = 0,1
- `cacheN_rd_en`  in  1  read request, held until `cacheN_rd_fin` seen
- `cacheN_rd_fin`  out  1  one-cycle read completion pulse
- `cacheN_rd_data`  out  DATA_W  read line, valid with `cacheN_rd_fin`, held until next read completion of port N
- `cacheN_wr_addr`  in  ADDR_W  write address
- `cacheN_wr_data`  in  DATA_W  write line
- `cacheN_wr_en`  in  1  write request, held until `cacheN_wr_fin` seen
- `cacheN_wr_fin`  out  1  one-cycle write completion pulse
- `arb2DDR_rd_addr` / `arb2DDR_rd_en`  out  ADDR_W / 1  DDR read request
- `DDR2arb_rd_fin` / `DDR2arb_rd_data`  in  1 / DATA_W  DDR read completion and data
- `arb2DDR_wr_addr` / `arb2DDR_wr_data` / `arb2DDR_wr_en`  out  ADDR_W / DATA_W / 1  DDR write request
- `DDR2arb_wr_fin`  in  1  DDR write completion
- `busy`  out  1  high in any state other than IDLE
- `grant_port`  out  1  port owning the current/last transaction

## Operation
- States: IDLE, ISSUE, RECOVER.
- IDLE: candidate set = ports with `rd_en|wr_en`. If empty, stay. If both, pick port != `last_port`; else the single requester. Op = write if that port's `wr_en`, else read. Latch port, op, address, write data into registers; go ISSUE. `last_port` <= chosen port.
- ISSUE: drive registered address/data and exactly one of `arb2DDR_rd_en` / `arb2DDR_wr_en`, held high every cycle of ISSUE. On sampled `fin` matching the op: capture `DDR2arb_rd_data` (read), pulse owner's matching `cacheN_*_fin` next cycle, drop DDR enable, go RECOVER. `fin` of the other op type ignored.
- RECOVER: DDR enables low. Return to IDLE on the first edge where both `DDR2arb_rd_fin` and `DDR2arb_wr_fin` sample low (tolerates DDR `fin` lasting more than one cycle). Minimum one cycle.
- Requester contract: `en` drops on the edge after its `fin` pulse; RECOVER guarantees that `en` is low before IDLE re-samples it.
- Request inputs are sampled only in IDLE; address/data changes during ISSUE have no effect.
- Never more than one DDR enable high; never a `fin` to a port that was not granted.

## Timing
- Reset values: all `cacheN_*_fin`, `cacheN_rd_data`, all `arb2DDR_*` outputs, `busy`, `grant_port` = 0; state IDLE; `last_port` = 1, so port 0 wins the first tie.
- `rst` mid-transaction: everything above cleared on that edge, in-flight DDR access abandoned, no `fin` issued.
- Request `en` high in cycle 0 -> DDR enable high in cycle 1. DDR `fin` in cycle k -> requester `fin` and DDR enable low in cycle k+1.
- Against the one-cycle demo memory (`fin` 1 cycle after enable, lasting 2 cycles): requester `fin` in cycle 3, IDLE in cycle 5, next grant's DDR enable in cycle 6.
- Back-to-back contention strictly alternates ports. A port with both `rd_en` and `wr_en` asserted is given write then read, on consecutive grants to that port.

## Test plan
- Single read, port 0, addr 0x0000010, DDR line preloaded with 0xA5..A5 -> `arb2DDR_rd_en` cycle 1, `cache0_rd_fin` pulse cycle 3 with `cache0_rd_data` = 0xA5..A5, port 1 outputs stay 0.
- Port 1 writes 0x1234 to 0x0000020, then port 1 reads 0x0000020 -> `cache1_wr_fin` once, then `cache1_rd_data` = 0x1234.
- Both ports request reads in the same cycle from reset -> port 0 granted first, port 1 second; 4 back-to-back rounds alternate 0,1,0,1.
- Port 0 asserts `rd_en` and `wr_en` together, same address, write data 0xBEEF -> write issued first, then read returns 0xBEEF; DDR enables never both high.
- DDR model holds `fin` high 3 cycles -> arbiter stays in RECOVER until `fin` low, exactly one requester `fin` pulse, no duplicate grant.
- `rst` asserted during ISSUE of a port 1 write -> next cycle all outputs 0, no `cache1_wr_fin`; a new port 0 request afterwards completes normally.
